// File: rtl/ifmap_row_streamer_if.sv
// SRAM read port and IFMap buffer write port seen by the row streamer.
// master = streamer side, slave = memory / buffer side.
interface ifmap_row_streamer_if #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 8
);
    logic                  mem_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH+1:0] fifo_din;
    logic                  fifo_wen;
    logic                  fifo_ready;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_data,
        output fifo_din,
        output fifo_wen,
        input  fifo_ready
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_data,
        input  fifo_din,
        input  fifo_wen,
        output fifo_ready
    );
endinterface

// File: rtl/ifmap_row_streamer.sv
// Streams num_rows x row_len IFMap words from SRAM into the PE IFMap buffer,
// tagging each word with {row_start,row_end} flags in the top two bits.
module ifmap_row_streamer #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 6,
    parameter int ROWS_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  row_len,
    input  logic [LEN_WIDTH-1:0]  row_stride,
    input  logic [ROWS_WIDTH-1:0] num_rows,
    output logic                  busy,
    output logic                  done,
    ifmap_row_streamer_if.master  bus
);

    localparam int WW = DATA_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  stride_q, stride_d;
    logic [ROWS_WIDTH-1:0] rows_q, rows_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [LEN_WIDTH-1:0]  word_q, word_d;
    logic [ROWS_WIDTH-1:0] row_q, row_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            tag_q, tag_d;
    logic [WW-1:0]         q0_q, q0_d;
    logic [WW-1:0]         q1_q, q1_d;
    logic [1:0]            cnt_q, cnt_d;

    logic                  cfg_zero;
    logic                  pop;
    logic                  push;
    logic [2:0]            occ;
    logic                  rd;
    logic                  row_last;
    logic                  last_row;
    logic                  last_rd;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [WW-1:0]         push_word;

    assign cfg_zero  = (row_len == '0) || (num_rows == '0);
    assign pop       = (cnt_q != 2'd0) && bus.fifo_ready;
    assign push      = inflight_q;
    assign push_word = {tag_q, bus.mem_data};

    // Queued words plus the read in flight, minus this cycle's pop, must leave room.
    assign occ      = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd       = (state_q == RUN) && (occ < 3'd2);
    assign row_last = (word_q == len_q - LEN_WIDTH'(1));
    assign last_row = (row_q == rows_q - ROWS_WIDTH'(1));
    assign last_rd  = rd && row_last && last_row;
    assign rd_addr  = row_base_q + ADDR_WIDTH'(word_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = cfg_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_rd) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight_q && (cnt_d == 2'd0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy         = (state_q == RUN) || (state_q == DRAIN);
        done         = (state_q == DONE);
        bus.mem_rd   = rd;
        bus.mem_addr = rd ? rd_addr : '0;
        bus.fifo_wen = pop;
        bus.fifo_din = (cnt_q != 2'd0) ? q0_q : '0;
    end

    always_comb begin
        len_d      = len_q;
        stride_d   = stride_q;
        rows_d     = rows_q;
        row_base_d = row_base_q;
        word_d     = word_q;
        row_d      = row_q;
        inflight_d = rd;
        tag_d      = {(word_q == '0), row_last};
        q0_d       = q0_q;
        q1_d       = q1_q;
        cnt_d      = cnt_q;

        if ((state_q == IDLE) && start) begin
            len_d      = row_len;
            stride_d   = row_stride;
            rows_d     = num_rows;
            row_base_d = base_addr;
            word_d     = '0;
            row_d      = '0;
        end

        // Walk the address with counters: next word, or jump to next row start.
        if (rd) begin
            if (row_last) begin
                word_d     = '0;
                row_d      = row_q + ROWS_WIDTH'(1);
                row_base_d = row_base_q + ADDR_WIDTH'(stride_q);
            end else begin
                word_d = word_q + LEN_WIDTH'(1);
            end
        end

        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    q0_d = push_word;
                end else begin
                    q1_d = push_word;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                q0_d  = q1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    q0_d = push_word;
                end else begin
                    q0_d = q1_q;
                    q1_d = push_word;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q      <= '0;
            stride_q   <= '0;
            rows_q     <= '0;
            row_base_q <= '0;
            word_q     <= '0;
            row_q      <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            q0_q       <= '0;
            q1_q       <= '0;
            cnt_q      <= '0;
        end else begin
            len_q      <= len_d;
            stride_q   <= stride_d;
            rows_q     <= rows_d;
            row_base_q <= row_base_d;
            word_q     <= word_d;
            row_q      <= row_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            q0_q       <= q0_d;
            q1_q       <= q1_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
